// File: rtl/uart_rx_front_if.sv
// Byte hand-off channel between the UART receive front end and the core logic.
// The master side drives data/valid and the slave side answers with ready.
interface uart_rx_front_if;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;

  modport master (output rx_data_o, output rx_valid_o, input rx_ready_i);
  modport slave  (input rx_data_o, input rx_valid_o, output rx_ready_i);
endinterface

// File: rtl/uart_rx_front.sv
// 8N1 serial receiver.
// It synchronises the line, samples each bit at mid-bit and passes bytes out
// through a valid/ready holding register, with sticky framing and overrun flags.
module uart_rx_front #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_i,
  uart_rx_front_if.master rx_bus,
  output logic            frame_err_o,
  output logic            overrun_o,
  input  logic            err_clr_i,
  output logic            busy_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e         state_q, state_d;
  logic           s1_q, rx_s_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     sh_q, sh_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           ovr_q, ovr_d;
  logic           busy_q;
  logic           cnt_clr, deliver, stop_err, xfer, load;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    cnt_clr  = 1'b0;
    idx_d    = idx_q;
    sh_d     = sh_q;
    deliver  = 1'b0;
    stop_err = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          if (!rx_s_q) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          sh_d = {rx_s_q, sh_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            cnt_clr = 1'b1;
          end
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            stop_err = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must return high before a new start is accepted.
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cnt_clr || (state_d != state_q)) cnt_d = '0;
  end

  // A transfer in the delivery cycle frees the holding register for the new byte.
  assign xfer    = valid_q && rx_bus.rx_ready_i;
  assign load    = deliver && (!valid_q || xfer);
  assign data_d  = load ? sh_q : data_q;
  assign valid_d = load ? 1'b1 : (xfer ? 1'b0 : valid_q);
  assign ferr_d  = stop_err ? 1'b1 : (err_clr_i ? 1'b0 : ferr_q);
  assign ovr_d   = (deliver && !load) ? 1'b1 : (err_clr_i ? 1'b0 : ovr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      sh_q    <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= rx_i;
      rx_s_q  <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign rx_bus.rx_data_o  = data_q;
  assign rx_bus.rx_valid_o = valid_q;
  assign frame_err_o       = ferr_q;
  assign overrun_o         = ovr_q;
  assign busy_o            = busy_q;
endmodule

// File: tb/tb_uart_rx_front.sv
// Directed bench for uart_rx_front: serial frames in, scoreboarded bytes out,
// plus timing, glitch, framing, overrun and reset scenarios at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_front;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_i = 1'b1;
  logic err_clr_i = 1'b0;
  logic frame_err_o, overrun_o, busy_o;

  uart_rx_front_if bus();

  uart_rx_front #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx_i),
    .rx_bus     (bus.master),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .err_clr_i  (err_clr_i),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_loads = 0;
  int last_load = 0;
  int prev_load = 0;
  int t0 = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic valid_at_edge = 1'b0;
  logic ready_at_edge = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    valid_at_edge <= bus.rx_valid_o;
    ready_at_edge <= bus.rx_ready_i;
  end

  // A load is a valid byte that was not already held (or whose predecessor just transferred).
  always @(negedge clk) begin
    if (bus.rx_valid_o && (!valid_at_edge || ready_at_edge)) begin
      n_loads++;
      prev_load = last_load;
      last_load = cyc;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_load observed=%h expected=none", bus.rx_data_o);
      end
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        $display("load cyc=%0d data=%h expected=%h", cyc, bus.rx_data_o, exp_b);
        checks++;
        assert (bus.rx_data_o === exp_b) else begin
          failures++;
          $error("FAIL load_data observed=%h expected=%h", bus.rx_data_o, exp_b);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx_i = b[k];
      repeat (CPB) @(negedge clk);
    end
    rx_i = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pulse_ready();
    bus.rx_ready_i = 1'b1;
    @(negedge clk);
    bus.rx_ready_i = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
  endtask

  initial begin
    bus.rx_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.rx_data_o, 8'h00);
    chk("rst_valid", bus.rx_valid_o, 0);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_ovr", overrun_o, 0);
    chk("rst_busy", busy_o, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte, held until a one-cycle ready pulse
    t0 = cyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    chk("t1_latency", last_load - t0, 155);
    repeat (50) @(negedge clk);
    chk("t1_hold_valid", bus.rx_valid_o, 1);
    chk("t1_hold_data", bus.rx_data_o, 8'hA5);
    pulse_ready();
    chk("t1_valid_drop", bus.rx_valid_o, 0);
    chk("t1_data_kept", bus.rx_data_o, 8'hA5);
    chk("t1_ferr", frame_err_o, 0);
    chk("t1_ovr", overrun_o, 0);

    // Back-to-back frames with ready tied high
    bus.rx_ready_i = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (5) @(negedge clk);
    chk("t2_loads", n_loads, 3);
    chk("t2_spacing", last_load - prev_load, 160);
    chk("t2_valid_pulse", bus.rx_valid_o, 0);
    chk("t2_ferr", frame_err_o, 0);
    chk("t2_ovr", overrun_o, 0);

    // Glitch: 4 low cycles are rejected at the mid-start sample
    repeat (10) @(negedge clk);
    t0 = cyc;
    rx_i = 1'b0;
    wait_cyc(t0 + 2);
    chk("t3_busy_pre", busy_o, 0);
    wait_cyc(t0 + 3);
    chk("t3_busy_e0", busy_o, 1);
    wait_cyc(t0 + 4);
    rx_i = 1'b1;
    wait_cyc(t0 + 10);
    chk("t3_busy_e7", busy_o, 1);
    wait_cyc(t0 + 11);
    chk("t3_busy_e8", busy_o, 0);
    repeat (30) @(negedge clk);
    chk("t3_loads", n_loads, 3);
    chk("t3_ferr", frame_err_o, 0);

    // Framing error followed by a break, then recovery
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    chk("t4_ferr", frame_err_o, 1);
    chk("t4_wait_high", busy_o, 1);
    chk("t4_no_valid", bus.rx_valid_o, 0);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4_idle", busy_o, 0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    repeat (3) @(negedge clk);
    chk("t4_loads", n_loads, 4);
    chk("t4_ferr_sticky", frame_err_o, 1);
    pulse_clr();
    chk("t4_ferr_clr", frame_err_o, 0);
    t0 = cyc;
    fork
      send_frame(8'h55, 1'b0);
      begin
        wait_cyc(t0 + 154);
        chk("t4_ferr_before", frame_err_o, 0);
        pulse_clr();
      end
    join
    chk("t4_set_wins", frame_err_o, 1);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    pulse_clr();

    // Overrun: second byte dropped while the first is held
    bus.rx_ready_i = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (3) @(negedge clk);
    chk("t5_data_kept", bus.rx_data_o, 8'h11);
    chk("t5_valid", bus.rx_valid_o, 1);
    chk("t5_ovr", overrun_o, 1);
    chk("t5_loads", n_loads, 5);
    pulse_ready();
    pulse_clr();
    chk("t5_ovr_clr", overrun_o, 0);

    // Ready pulsed exactly in the load cycle frees the register in time
    t0 = cyc;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        wait_cyc(t0 + 314);
        pulse_ready();
      end
    join
    repeat (3) @(negedge clk);
    chk("t5b_data", bus.rx_data_o, 8'h22);
    chk("t5b_valid", bus.rx_valid_o, 1);
    chk("t5b_ovr", overrun_o, 0);
    chk("t5b_loads", n_loads, 7);
    pulse_ready();

    // Reset in the middle of data bit 3
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    repeat (2) @(negedge clk);
    chk("t6_pre_ovr", overrun_o, 1);
    chk("t6_pre_valid", bus.rx_valid_o, 1);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_pre_busy", busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx_i = 1'b1;
    chk("t6_rst_data", bus.rx_data_o, 8'h00);
    chk("t6_rst_valid", bus.rx_valid_o, 0);
    chk("t6_rst_ferr", frame_err_o, 0);
    chk("t6_rst_ovr", overrun_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    repeat (30) @(negedge clk);
    chk("t6_idle", busy_o, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (3) @(negedge clk);
    chk("t6_data", bus.rx_data_o, 8'h5A);
    chk("t6_loads", n_loads, 9);

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
